// File: rtl/risc_v_mike_pkg.sv
// rtl/risc_v_mike_pkg.sv - shared types and constants for the risc_v_mike MMIO peripherals
// Contents: UART TX framing state enum, UART TX register offsets, status field width.
package risc_v_mike_pkg;

   typedef enum logic [1:0] {
      UART_TX_IDLE,
      UART_TX_START,
      UART_TX_DATA,
      UART_TX_STOP
   } t_uart_tx_state;

   localparam logic [31:0] UART_TX_DATA_OFFSET   = 32'd0;
   localparam logic [31:0] UART_TX_STATUS_OFFSET = 32'd4;
   localparam int          UART_TX_STATUS_W      = 12;

endpackage

// File: rtl/risc_v_mike_sync_fifo.sv
// rtl/risc_v_mike_sync_fifo.sv - single-clock FIFO with occupancy count
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i/push_data_i write request and data; accepted when not full or when popping
//   pop_i/pop_data_o   read request; pop_data_o is the current head (show-ahead)
//   full_o, empty_o, count_o  occupancy flags and count (one bit wider than pointers)
module risc_v_mike_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is still taken when the head leaves the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/risc_v_mike_mmio_uart_tx.sv
// rtl/risc_v_mike_mmio_uart_tx.sv - MMIO UART transmitter (8N1) with TX FIFO and status register
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   data_mmio_addr         byte address; MMIO_BASE = TX data, MMIO_BASE+4 = status
//   data_mmio_wr_addr_val  write strobe
//   data_mmio_wr_data      store data, [7:0] used for TX data
//   data_mmio_rd_data      combinational read: {20'b0, count, overflow, busy, empty, full}
//   tx                     registered serial output, idle high
module risc_v_mike_mmio_uart_tx
   import risc_v_mike_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_mmio_addr,
   input  logic        data_mmio_wr_addr_val,
   input  logic [31:0] data_mmio_wr_data,
   output logic [31:0] data_mmio_rd_data,
   output logic        tx
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

   t_uart_tx_state    state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              overflow_q, overflow_d;

   logic              fifo_pop;
   logic [7:0]        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic              data_sel, status_sel;
   logic              data_wr, status_wr;
   logic              busy;
   logic [UART_TX_STATUS_W-1:0] status;
   logic              unused_wr_data;

   assign data_sel   = (data_mmio_addr == MMIO_BASE + UART_TX_DATA_OFFSET);
   assign status_sel = (data_mmio_addr == MMIO_BASE + UART_TX_STATUS_OFFSET);
   assign data_wr    = data_mmio_wr_addr_val && data_sel;
   assign status_wr  = data_mmio_wr_addr_val && status_sel;
   assign unused_wr_data = ^data_mmio_wr_data[31:8];

   risc_v_mike_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (data_wr),
      .push_data_i (data_mmio_wr_data[7:0]),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Set wins over a same-cycle clear from a status write.
   assign overflow_d = (data_wr && fifo_full && !fifo_pop) || (overflow_q && !status_wr);

   assign busy   = (state_q != UART_TX_IDLE);
   assign status = {8'(fifo_count), overflow_q, busy, fifo_empty, fifo_full};
   assign data_mmio_rd_data = status_sel ? {{(32-UART_TX_STATUS_W){1'b0}}, status} : 32'h0;
   assign tx = tx_q;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      case (state_q)
         UART_TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               baud_d   = '0;
               bit_d    = '0;
               state_d  = UART_TX_START;
            end
         end
         UART_TX_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = UART_TX_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         UART_TX_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = UART_TX_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         UART_TX_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_head;
                  bit_d    = '0;
                  state_d  = UART_TX_START;
               end else begin
                  state_d = UART_TX_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = UART_TX_IDLE;
      endcase

      // The line level is decided from the upcoming state so tx leaves a flop
      // aligned with the state it belongs to.
      case (state_d)
         UART_TX_START: tx_d = 1'b0;
         UART_TX_DATA:  tx_d = shift_d[0];
         default:       tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= UART_TX_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
